// File: rtl/memory_arbiter_rr.sv
// Arbitrates NUM_REQ requesters onto one memory port by fixed priority or round-robin.
// Registered outputs, one edge from req to grant; grants last up to BURST_LEN cycles, then one idle turnaround cycle.
module memory_arbiter_rr #(
  parameter  int NUM_REQ   = 4,
  parameter  int BURST_LEN = 4,
  parameter  int MODE      = 1,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic [7:0]         burst_cnt,
  output logic [1:0]         arbiter_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01,
    S_TURN  = 2'b10,
    S_BAD   = 2'b11
  } state_t;

  localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [7:0]    BLEN   = 8'(BURST_LEN);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               vld_q, vld_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  logic [ID_W-1:0]    base;
  logic [ID_W:0]      sum;
  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W:0]      owner_inc;
  logic [ID_W-1:0]    owner_next;
  logic               release_now;

  // Circular search starting at base; fixed priority simply starts at 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    base      = (MODE == 1) ? ptr_q : '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, base} + (ID_W+1)'(i);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!win_found && req[sum[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    owner_inc  = {1'b0, id_q} + {{ID_W{1'b0}}, 1'b1};
    owner_next = (owner_inc >= NREQ_W) ? '0 : owner_inc[ID_W-1:0];
  end

  assign release_now = !req[id_q] || (cnt_q == BLEN);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    vld_d   = vld_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE, S_TURN: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          vld_d            = 1'b1;
          id_d             = win_idx;
          cnt_d            = 8'd1;
          state_d          = S_GRANT;
        end else begin
          grant_d = '0;
          vld_d   = 1'b0;
          id_d    = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (release_now) begin
          grant_d = '0;
          vld_d   = 1'b0;
          id_d    = '0;
          cnt_d   = '0;
          state_d = S_TURN;
          if (MODE == 1) ptr_d = owner_next;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean idle.
        grant_d = '0;
        vld_d   = 1'b0;
        id_d    = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = vld_q;
  assign grant_id      = id_q;
  assign burst_cnt     = cnt_q;
  assign arbiter_state = state_q;

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// Bench for memory_arbiter_rr: round-robin, fixed-priority and single-cycle-burst instances
// driven by the same request stream and checked against a cycle-level reference model.
module tb_memory_arbiter_rr;

  logic       clk;
  logic       reset;
  logic [3:0] req;

  logic [3:0] g0, g1, g2;
  logic       v0, v1, v2;
  logic [1:0] id0, id1, id2;
  logic [7:0] c0, c1, c2;
  logic [1:0] s0, s1, s2;

  memory_arbiter_rr #(.NUM_REQ(4), .BURST_LEN(4), .MODE(1)) u_rr (
    .clk(clk), .reset(reset), .req(req), .grant(g0), .grant_valid(v0),
    .grant_id(id0), .burst_cnt(c0), .arbiter_state(s0));

  memory_arbiter_rr #(.NUM_REQ(4), .BURST_LEN(4), .MODE(0)) u_fp (
    .clk(clk), .reset(reset), .req(req), .grant(g1), .grant_valid(v1),
    .grant_id(id1), .burst_cnt(c1), .arbiter_state(s1));

  memory_arbiter_rr #(.NUM_REQ(4), .BURST_LEN(1), .MODE(1)) u_b1 (
    .clk(clk), .reset(reset), .req(req), .grant(g2), .grant_valid(v2),
    .grant_id(id2), .burst_cnt(c2), .arbiter_state(s2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model per instance: owner (-1 = none), cycles held, rr pointer, phase 0/1/2.
  int m_owner [3];
  int m_cnt   [3];
  int m_ptr   [3];
  int m_phase [3];
  int mode_k  [3] = '{1, 0, 1};
  int blen_k  [3] = '{4, 4, 1};

  logic [16:0] expq [3][$];

  function automatic int win(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (p + i) % 4;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset(input int k);
    m_owner[k] = -1;
    m_cnt[k]   = 0;
    m_ptr[k]   = 0;
    m_phase[k] = 0;
  endtask

  task automatic model_step(input int k, input logic [3:0] r);
    if (m_phase[k] == 1) begin
      if (!r[m_owner[k]] || m_cnt[k] == blen_k[k]) begin
        if (mode_k[k] == 1) m_ptr[k] = (m_owner[k] + 1) % 4;
        m_owner[k] = -1;
        m_cnt[k]   = 0;
        m_phase[k] = 2;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
      end
    end else if (r != 4'b0000) begin
      m_owner[k] = win(r, (mode_k[k] == 1) ? m_ptr[k] : 0);
      m_cnt[k]   = 1;
      m_phase[k] = 1;
    end else begin
      m_phase[k] = 0;
    end
  endtask

  function automatic logic [16:0] exp_of(input int k);
    logic [3:0] g;
    logic [1:0] id;
    g  = 4'b0000;
    id = 2'd0;
    if (m_owner[k] >= 0) begin
      g[m_owner[k]] = 1'b1;
      id = 2'(m_owner[k]);
    end
    return {g, |g, id, 8'(m_cnt[k]), 2'(m_phase[k])};
  endfunction

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got grant=%b vld=%b id=%0d cnt=%0d st=%b, want grant=%b vld=%b id=%0d cnt=%0d st=%b",
               name, $time, act[16:13], act[12], act[11:10], act[9:2], act[1:0],
               exp[16:13], exp[12], exp[11:10], exp[9:2], exp[1:0]);
    end
  endtask

  // Drive one cycle of stimulus and queue what each instance must show after the next edge.
  task automatic cycle(input logic [3:0] r, input logic rst_n);
    @(negedge clk);
    reset = rst_n;
    req   = r;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) model_reset(k);
      else        model_step(k, r);
      expq[k].push_back(exp_of(k));
    end
  endtask

  initial begin : monitor
    logic [16:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (expq[0].size() > 0) begin
        e = expq[0].pop_front();
        chk("rr", {g0, v0, id0, c0, s0}, e);
      end
      if (expq[1].size() > 0) begin
        e = expq[1].pop_front();
        chk("fp", {g1, v1, id1, c1, s1}, e);
      end
      if (expq[2].size() > 0) begin
        e = expq[2].pop_front();
        chk("b1", {g2, v2, id2, c2, s2}, e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b0;
    req   = 4'b1111;
    for (int k = 0; k < 3; k++) model_reset(k);

    // Held in reset with all requests active: nothing may be granted.
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 1'b0);
      #1;
      chk("in_reset_rr", {g0, v0, id0, c0, s0}, 17'd0);
    end

    // Everybody requesting: rr rotates with ptr wrap, fp sticks to requester 0.
    for (int i = 0; i < 22; i++) cycle(4'b1111, 1'b1);
    for (int i = 0; i < 2; i++)  cycle(4'b0000, 1'b1);
    for (int i = 0; i < 12; i++) cycle(4'b0001, 1'b1);
    for (int i = 0; i < 3; i++)  cycle(4'b0000, 1'b1);
    // Owner drops its request part-way through a burst.
    for (int i = 0; i < 2; i++)  cycle(4'b0011, 1'b1);
    for (int i = 0; i < 6; i++)  cycle(4'b0010, 1'b1);

    for (int s = 0; s < 40; s++) begin
      logic [3:0] r;
      int hold;
      r    = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 8);
      for (int i = 0; i < hold; i++) cycle(r, 1'b1);
    end

    // Asynchronous reset while requester 2 owns the rr instance.
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0100, 1'b1);
    cycle(4'b0100, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_rr", {g0, v0, id0, c0, s0}, 17'd0);
    chk("async_rst_fp", {g1, v1, id1, c1, s1}, 17'd0);
    chk("async_rst_b1", {g2, v2, id2, c2, s2}, 17'd0);
    cycle(4'b1100, 1'b0);
    for (int i = 0; i < 8; i++) cycle(4'b1100, 1'b1);

    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1);
    @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (expq[k].size() != 0) begin
        bad++;
        $display("FAIL drain: instance %0d left %0d unchecked, want 0", k, expq[k].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_arbiter_rr.md
Name: memory_arbiter_rr

Overview:
Parametrised successor to the 3-requester memory controller arbiter. It arbitrates NUM_REQ requesters onto one shared memory port, either by fixed priority or by round-robin. Each grant is held for a bounded burst. A one-cycle bus turnaround follows every grant. It sits between the requester front-ends and the memory port mux, and drives the mux select directly from grant_id.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
BURST_LEN, 4, maximum consecutive cycles one grant is held (1..255)
MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
ID_W, $clog2(NUM_REQ), width of grant_id (localparam, derived)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  NUM_REQ  request vector; bit i = requester i wants the port
grant  output  NUM_REQ  registered one-hot grant; all-zero when no owner
grant_valid  output  1  registered; equals OR of grant
grant_id  output  ID_W  registered index of the owner; 0 when grant_valid=0
burst_cnt  output  8  registered count of cycles granted to the current owner (1..BURST_LEN); 0 when idle
arbiter_state  output  2  debug encoding: 00 IDLE, 01 GRANT, 10 TURN, 11 unused

Behaviour:
- Reset (reset=0, asynchronous): all of the following apply immediately, independent of clk, and hold while reset=0.
  - grant=0, grant_valid=0, grant_id=0, burst_cnt=0.
  - state=IDLE; round-robin pointer ptr=0.
- All outputs are registered; req is sampled on the rising edge of clk.
- Winner selection (combinational, from sampled req):
  - MODE=0: lowest set index.
  - MODE=1: first set index searching ptr, ptr+1, … wrapping modulo NUM_REQ.
- IDLE:
  - req==0: stay in IDLE.
  - else: grant <= onehot(winner), grant_id <= winner, burst_cnt <= 1, go to GRANT.
  - Latency from req to grant is one edge.
- GRANT:
  - Release condition: req[owner]==0 or burst_cnt==BURST_LEN.
  - On release: grant <= 0, grant_id <= 0, burst_cnt <= 0, go to TURN.
  - Also on release in MODE=1: ptr <= (owner+1) mod NUM_REQ.
  - Otherwise: burst_cnt <= burst_cnt+1, grant unchanged.
  - Requests from other requesters never preempt the owner.
- TURN: always exactly one cycle with grant=0.
  - req!=0: grant the winner, evaluated with the updated ptr, and go to GRANT.
  - req==0: go to IDLE.
- Simultaneous events:
  - Owner drop and burst expiry on the same edge: a single release, one TURN cycle.
  - Requester dropping req during TURN: not considered; only the req sampled at the TURN edge counts.
- A requester that keeps req high is re-granted after TURN only if it is the winner. In MODE=1 with other requesters active, that is never the case on the immediately following grant.
- BURST_LEN=1: alternates GRANT/TURN every cycle while requests persist.
- ptr wraps from NUM_REQ-1 to 0.
- arbiter_state=11 is illegal: next edge forces IDLE with all outputs cleared.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid==|grant.
  - grant_id matches the set bit of grant.

Test Plan (NUM_REQ=4, BURST_LEN=4 unless noted):
1. reset=0 with req=4'b1111 -> grant=0000, arbiter_state=00 throughout reset; then reset=1 -> at the first edge grant=0001, grant_id=0, burst_cnt=1, arbiter_state=01.
2. MODE=1, req=4'b0001 held -> grant=0001 for 4 cycles (burst_cnt 1..4), then 1 cycle 0000 with state 10, then 0001 again; the pattern repeats.
3. MODE=1, req=4'b1111 held -> grant sequence 0001×4, 0000, 0010×4, 0000, 0100×4, 0000, 1000×4, 0000, then 0001 (ptr wrap).
4. MODE=1, req=4'b0011, requester 0 drops req after its 2nd grant cycle -> next edge grant=0000 (TURN), then grant=0010 with burst_cnt=1.
5. MODE=0, req=4'b1111 held -> 0001×4, 0000, 0001×4 repeats; requester 0 always wins, and grant_id never leaves 0 when valid.
6. MODE=1, reset driven to 0 mid-GRANT on requester 2, asynchronously between edges -> grant=0000 and state=00 immediately without a clock edge; after release with req=4'b1100 -> grant=0100 (ptr back to 0, search from index 0).
